// File: rtl/mux_select_arbiter_pkg.sv
// Shared types and constants for the two-line multiplexer select arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  localparam int ARB_BURST_DEFAULT = 4;
  localparam int ARB_CNT_W         = 4;

  // Grant state that corresponds to a given line index.
  function automatic arb_state_t grant_state(input logic line);
    grant_state = line ? ARB_GNT1 : ARB_GNT0;
  endfunction

endpackage

// File: rtl/mux_select_arbiter_if.sv
// Request/grant/select bundle between the two sources, the consumer and the arbiter.
interface mux_select_arbiter_if;

  logic req0;
  logic req1;
  logic out_ready;
  logic select;
  logic gnt0;
  logic gnt1;
  logic out_valid;

  modport master (
    output req0,
    output req1,
    output out_ready,
    input  select,
    input  gnt0,
    input  gnt1,
    input  out_valid
  );

  modport slave (
    input  req0,
    input  req1,
    input  out_ready,
    output select,
    output gnt0,
    output gnt1,
    output out_valid
  );

endinterface

// File: rtl/mux_select_arbiter_burst_counter.sv
// Beat counter for the current grant; flags the beat that completes the burst.
module burst_counter
  import mux_arb_pkg::*;
#(
  parameter int BURST = ARB_BURST_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  input  logic i_incr,
  output logic o_terminal
);

  localparam logic [ARB_CNT_W-1:0] LP_LAST = ARB_CNT_W'(BURST - 1);

  logic [ARB_CNT_W-1:0] r_count;

  // Count transferred beats; clear wins over increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {ARB_CNT_W{1'b0}};
    end else if (i_clear) begin
      r_count <= {ARB_CNT_W{1'b0}};
    end else if (i_incr) begin
      r_count <= r_count + {{(ARB_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_terminal = i_incr & (r_count == LP_LAST);

endmodule

// File: rtl/mux_select_arbiter.sv
// Round-robin burst arbiter driving the select of a downstream 2:1 multiplexer.
module mux_select_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST = ARB_BURST_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mux_select_arbiter_if.slave  bus
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_select;
  logic       r_last_grant;
  logic       w_enter;
  logic       w_exit;
  logic       w_clear;
  logic       w_xfer;
  logic       w_terminal;
  logic       w_own_line;
  logic       w_req_own;
  logic       w_req_oth;

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.select    = r_select;
  assign bus.out_valid = (r_gnt0 & bus.req0) | (r_gnt1 & bus.req1);

  assign w_xfer     = bus.out_valid & bus.out_ready;
  assign w_own_line = (r_state == ARB_GNT1);
  assign w_req_own  = w_own_line ? bus.req1 : bus.req0;
  assign w_req_oth  = w_own_line ? bus.req0 : bus.req1;
  assign w_exit     = (r_state != ARB_IDLE) & (w_terminal | ~w_req_own);
  assign w_clear    = (w_next != r_state) | w_exit;

  burst_counter #(
    .BURST (BURST)
  ) u_burst_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_clear    (w_clear),
    .i_incr     (w_xfer),
    .o_terminal (w_terminal)
  );

  // Next-state selection; a re-entry into the same grant still counts as an entry.
  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (bus.req0 && bus.req1) begin
          w_next  = grant_state(~r_last_grant);
          w_enter = 1'b1;
        end else if (bus.req0) begin
          w_next  = ARB_GNT0;
          w_enter = 1'b1;
        end else if (bus.req1) begin
          w_next  = ARB_GNT1;
          w_enter = 1'b1;
        end else begin
          w_next  = ARB_IDLE;
        end
      end
      ARB_GNT0, ARB_GNT1: begin
        if (w_exit) begin
          if (w_req_oth) begin
            w_next  = grant_state(~w_own_line);
            w_enter = 1'b1;
          end else if (w_req_own) begin
            w_next  = r_state;
            w_enter = 1'b1;
          end else begin
            w_next  = ARB_IDLE;
          end
        end else begin
          w_next = r_state;
        end
      end
      default: begin
        w_next = ARB_IDLE;
      end
    endcase
  end

  // State, grant and select registers; last_grant starts at line1 so line0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ARB_IDLE;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_select     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_next;
      r_gnt0  <= (w_next == ARB_GNT0);
      r_gnt1  <= (w_next == ARB_GNT1);
      if (w_enter) begin
        r_select     <= (w_next == ARB_GNT1);
        r_last_grant <= (w_next == ARB_GNT1);
      end else begin
        r_select     <= r_select;
        r_last_grant <= r_last_grant;
      end
    end
  end

endmodule
